// File: rtl/mic_adc_reader_if.sv
// mic_adc_reader_if
// Groups the reader's control input, the ADC serial bus and the sample outputs.
//   master : the reader (drives cs_n/sclk and the sample outputs; reads enable, miso)
//   slave  : the environment (drives enable and the ADC's miso; observes the rest)
interface mic_adc_reader_if;
    logic        enable;
    logic        miso;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample;
    logic [11:0] sample_signed;
    logic        sample_valid;
    logic        frame_err;
    logic        overrun;

    modport master (
        input  enable, miso,
        output cs_n, sclk, sample, sample_signed, sample_valid, frame_err, overrun
    );

    modport slave (
        output enable, miso,
        input  cs_n, sclk, sample, sample_signed, sample_valid, frame_err, overrun
    );
endinterface

// File: rtl/mic_adc_reader.sv
// mic_adc_reader
// SPI master for a 12-bit serial microphone ADC (16-bit frame: 4 leading zero
// bits followed by 12 data bits, MSB first). A free-running sample timer
// requests one conversion every SAMPLE_DIV clocks while enable is high.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : mic_adc_reader_if.master (enable, miso in; cs_n, sclk, sample,
//            sample_signed, sample_valid, frame_err, overrun out)
module mic_adc_reader #(
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 2500
) (
    input  logic             clk,
    input  logic             reset,
    mic_adc_reader_if.master bus
);
    localparam int TIMER_W = $clog2(SAMPLE_DIV);
    // div_reg must reach 2*CLK_DIV-1 for the QUIET interval.
    localparam int DIV_W   = $clog2(2 * CLK_DIV);

    typedef enum logic [1:0] {IDLE, CONV, HOLD, QUIET} state_t;

    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [4:0]           half_reg, half_next;
    logic [15:0]          shift_reg, shift_next;
    logic                 cs_n_reg, cs_n_next;
    logic                 sclk_reg, sclk_next;
    logic [11:0]          sample_reg, sample_next;
    logic [11:0]          sample_signed_reg, sample_signed_next;
    logic                 valid_reg, valid_next;
    logic                 err_reg, err_next;
    logic                 overrun_reg, overrun_next;
    logic                 tick;
    logic                 div_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            timer_reg         <= '0;
            div_reg           <= '0;
            half_reg          <= '0;
            shift_reg         <= '0;
            cs_n_reg          <= 1'b1;
            sclk_reg          <= 1'b1;
            sample_reg        <= '0;
            sample_signed_reg <= 12'h800;
            valid_reg         <= 1'b0;
            err_reg           <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            timer_reg         <= timer_next;
            div_reg           <= div_next;
            half_reg          <= half_next;
            shift_reg         <= shift_next;
            cs_n_reg          <= cs_n_next;
            sclk_reg          <= sclk_next;
            sample_reg        <= sample_next;
            sample_signed_reg <= sample_signed_next;
            valid_reg         <= valid_next;
            err_reg           <= err_next;
            overrun_reg       <= overrun_next;
        end
    end

    always_comb begin
        tick     = bus.enable && (timer_reg == TIMER_W'(SAMPLE_DIV - 1));
        div_last = (div_reg == DIV_W'(CLK_DIV - 1));

        // Timer is held at zero while disabled so the first tick after
        // enable rises always comes a full SAMPLE_DIV period later.
        timer_next         = (bus.enable && !tick) ? timer_reg + 1'b1 : '0;
        state_next         = state_reg;
        div_next           = div_reg;
        half_next          = half_reg;
        shift_next         = shift_reg;
        cs_n_next          = cs_n_reg;
        sclk_next          = sclk_reg;
        sample_next        = sample_reg;
        sample_signed_next = sample_signed_reg;
        valid_next         = 1'b0;
        err_next           = err_reg;
        // Any tick that cannot start a frame is lost; flag it for good.
        overrun_next       = overrun_reg | (tick && (state_reg != IDLE));

        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next = CONV;
                    cs_n_next  = 1'b0;
                    div_next   = '0;
                    half_next  = '0;
                end
            end
            CONV: begin
                if (div_last) begin
                    div_next  = '0;
                    // Even half-periods end with a falling edge, odd ones
                    // with a rising edge; data is captured on the rising one.
                    sclk_next = ~sclk_reg;
                    half_next = half_reg + 1'b1;
                    if (half_reg[0]) begin
                        shift_next = {shift_reg[14:0], bus.miso};
                    end
                    if (half_reg == 5'd31) begin
                        state_next = HOLD;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            HOLD: begin
                if (div_last) begin
                    div_next           = '0;
                    cs_n_next          = 1'b1;
                    sample_next        = shift_reg[11:0];
                    sample_signed_next = {~shift_reg[11], shift_reg[10:0]};
                    err_next           = |shift_reg[15:12];
                    valid_next         = 1'b1;
                    state_next         = QUIET;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            QUIET: begin
                if (div_reg == DIV_W'(2 * CLK_DIV - 1)) begin
                    div_next   = '0;
                    state_next = IDLE;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cs_n          = cs_n_reg;
    assign bus.sclk          = sclk_reg;
    assign bus.sample        = sample_reg;
    assign bus.sample_signed = sample_signed_reg;
    assign bus.sample_valid  = valid_reg;
    assign bus.frame_err     = err_reg;
    assign bus.overrun       = overrun_reg;
endmodule

// File: tb/tb_mic_adc_reader.sv
// tb_mic_adc_reader
// Self-checking bench for mic_adc_reader: a fixed vector table, randomized
// frames checked against a arithmetic reference model, and hand-written
// sequences for enable drop, reset abort and overrun.
module tb_mic_adc_reader;
    localparam int CD   = 2;
    localparam int SD   = 100;
    localparam int SD_B = 50;

    typedef struct {
        logic [15:0] word;
        logic [11:0] exp_sample;
        logic [11:0] exp_signed;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mic_adc_reader_if a_if ();
    mic_adc_reader_if b_if ();

    mic_adc_reader #(.CLK_DIV(CD), .SAMPLE_DIV(SD)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.master)
    );
    mic_adc_reader #(.CLK_DIV(CD), .SAMPLE_DIV(SD_B)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.master)
    );

    // ADC model: shifts the frame word out MSB first on sclk falling edges.
    logic [15:0] word_a = 16'h0000;
    int          bit_a  = 0;
    always @(negedge a_if.cs_n) bit_a = 0;
    always @(negedge a_if.sclk) begin
        if (a_if.cs_n === 1'b0 && bit_a < 16) begin
            a_if.miso = word_a[15 - bit_a];
            bit_a = bit_a + 1;
        end
    end

    // Count sclk transitions that happen while cs_n stays high.
    int   idle_toggles = 0;
    logic prev_cs      = 1'b1;
    logic prev_sclk    = 1'b1;
    always @(negedge clk) begin
        if (prev_cs === 1'b1 && a_if.cs_n === 1'b1 && a_if.sclk !== prev_sclk)
            idle_toggles++;
        prev_cs   = a_if.cs_n;
        prev_sclk = a_if.sclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_sample(input int w);
        return 12'(w % 4096);
    endfunction
    function automatic logic [11:0] ref_signed(input int w);
        return 12'((w % 4096 + 2048) % 4096);
    endfunction
    function automatic logic ref_err(input int w);
        return (w / 4096) != 0;
    endfunction

    // Waits for the next cs_n fall, then follows the frame to sample_valid.
    // gap = negedges waited before the fall, lat = cycles from fall to valid.
    task automatic run_frame(input logic [15:0] w, output logic [11:0] s,
                             output logic [11:0] ss, output logic fe, output int gap,
                             output int lat, output int rises, output int fall_cyc,
                             output logic cs_at_valid);
        logic ps;
        word_a = w;
        gap = 0; lat = -1; rises = 0; fall_cyc = -1;
        s = '0; ss = '0; fe = 1'b0; cs_at_valid = 1'b0;
        while (a_if.cs_n !== 1'b0 && gap < 1000) begin
            @(negedge clk);
            gap++;
        end
        if (a_if.cs_n === 1'b0) begin
            fall_cyc = cyc;
            ps = a_if.sclk;
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (ps === 1'b0 && a_if.sclk === 1'b1) rises++;
                ps = a_if.sclk;
                if (a_if.sample_valid === 1'b1) begin
                    lat = i;
                    s = a_if.sample; ss = a_if.sample_signed; fe = a_if.frame_err;
                    cs_at_valid = a_if.cs_n;
                    break;
                end
            end
        end
    endtask

    initial begin
        logic [11:0] s, ss;
        logic        fe, csv, prev_b;
        int          gap, lat, rises, fc, prev_fc, n, w, hits, last, exp_ovr, obs_ovr;
        int          starts[$];
        int          exp_starts[$];

        vecs[0] = '{16'h0ABC, 12'hABC, 12'h2BC, 1'b0};
        vecs[1] = '{16'h8123, 12'h123, 12'h923, 1'b1};
        vecs[2] = '{16'h0000, 12'h000, 12'h800, 1'b0};
        vecs[3] = '{16'hFFFF, 12'hFFF, 12'h7FF, 1'b1};
        vecs[4] = '{16'h0800, 12'h800, 12'h000, 1'b0};
        vecs[5] = '{16'h07FF, 12'h7FF, 12'hFFF, 1'b0};
        vecs[6] = '{16'h1000, 12'h000, 12'h800, 1'b1};

        reset = 1'b1;
        a_if.enable = 1'b0; a_if.miso = 1'b0;
        b_if.enable = 1'b0; b_if.miso = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", a_if.cs_n, 1);
        chk("rst_sclk", a_if.sclk, 1);
        chk("rst_sample", a_if.sample, 0);
        chk("rst_signed", a_if.sample_signed, 12'h800);
        chk("rst_valid", a_if.sample_valid, 0);
        chk("rst_frame_err", a_if.frame_err, 0);
        chk("rst_overrun", a_if.overrun, 0);

        reset = 1'b0;
        a_if.enable = 1'b1;
        prev_fc = -1;

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].word, s, ss, fe, gap, lat, rises, fc, csv);
            $display("vec %0d word=%h sample=%h signed=%h err=%b lat=%0d rises=%0d gap=%0d",
                     i, vecs[i].word, s, ss, fe, lat, rises, gap);
            chk("vec_sample", s, vecs[i].exp_sample);
            chk("vec_signed", ss, vecs[i].exp_signed);
            chk("vec_frame_err", fe, vecs[i].exp_err);
            chk("vec_latency", lat, 33 * CD);
            chk("vec_sclk_rises", rises, 16);
            chk("vec_cs_high_at_valid", csv, 1);
            if (i == 0) chk("first_tick_delay", gap, SD);
            else begin
                chk("frame_period", fc - prev_fc, SD);
                chk("quiet_gap_ge4", gap >= 4, 1);
            end
            prev_fc = fc;
            @(negedge clk);
            chk("valid_single_pulse", a_if.sample_valid, 0);
            chk("sample_hold", a_if.sample, vecs[i].exp_sample);
        end

        // Randomized frames against the arithmetic reference model.
        for (int i = 0; i < 10; i++) begin
            w = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) w = w % 4096;
            run_frame(16'(w), s, ss, fe, gap, lat, rises, fc, csv);
            $display("rnd %0d word=%h sample=%h signed=%h err=%b lat=%0d", i, w[15:0], s, ss, fe, lat);
            chk("rnd_sample", s, ref_sample(w));
            chk("rnd_signed", ss, ref_signed(w));
            chk("rnd_frame_err", fe, ref_err(w));
            chk("rnd_latency", lat, 33 * CD);
            chk("rnd_period", fc - prev_fc, SD);
            prev_fc = fc;
            @(negedge clk);
        end
        chk("no_overrun_at_nominal_rate", a_if.overrun, 0);
        chk("no_sclk_while_cs_high", idle_toggles, 0);

        // enable drops at t=10: frame still completes, then nothing starts.
        word_a = 16'h05A5;
        n = 0;
        while (a_if.cs_n !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        a_if.enable = 1'b0;
        hits = 0;
        for (int i = 0; i < 200 && hits == 0; i++) begin
            @(negedge clk);
            if (a_if.sample_valid === 1'b1) hits = 1;
        end
        $display("enable drop: valid=%0d sample=%h", hits, a_if.sample);
        chk("drop_valid_seen", hits, 1);
        chk("drop_sample", a_if.sample, 12'h5A5);
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_if.cs_n === 1'b0) hits++;
        end
        chk("drop_no_new_frame", hits, 0);
        a_if.enable = 1'b1;
        run_frame(16'h0321, s, ss, fe, gap, lat, rises, fc, csv);
        $display("re-enable: gap=%0d sample=%h", gap, s);
        chk("reenable_timer_from_zero", gap, SD);
        chk("reenable_sample", s, 12'h321);

        // Reset at t=18 of a frame (sclk low) aborts it immediately.
        word_a = 16'h0FFF;
        n = 0;
        while (a_if.cs_n !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        repeat (18) @(negedge clk);
        chk("pre_abort_sclk_low", a_if.sclk, 0);
        #1 reset = 1'b1;
        #1;
        chk("abort_cs_n", a_if.cs_n, 1);
        chk("abort_sclk", a_if.sclk, 1);
        chk("abort_sample", a_if.sample, 0);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_if.sample_valid !== 1'b0) hits++;
        end
        reset = 1'b0;
        chk("abort_no_valid", hits, 0);
        run_frame(16'h0F0F, s, ss, fe, gap, lat, rises, fc, csv);
        $display("after abort: gap=%0d sample=%h lat=%0d", gap, s, lat);
        chk("post_abort_gap", gap, SD);
        chk("post_abort_sample", s, 12'hF0F);
        chk("post_abort_latency", lat, 33 * CD);
        chk("post_abort_rises", rises, 16);

        // Overrun: ticks every 50 cycles, frame needs 35*CD+1.
        exp_ovr = -1; last = -1000;
        for (int k = 1; k * SD_B <= 500; k++) begin
            if (k * SD_B - last >= 35 * CD + 1) begin
                exp_starts.push_back(k * SD_B);
                last = k * SD_B;
            end else if (exp_ovr < 0) exp_ovr = k * SD_B;
        end
        b_if.enable = 1'b1;
        prev_b = b_if.cs_n;
        obs_ovr = -1;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (prev_b === 1'b1 && b_if.cs_n === 1'b0) starts.push_back(i);
            if (b_if.overrun === 1'b1 && obs_ovr < 0) obs_ovr = i;
            prev_b = b_if.cs_n;
        end
        $display("overrun: starts=%0d first_overrun=%0d", starts.size(), obs_ovr);
        chk("ovr_start_count", starts.size(), exp_starts.size());
        for (int i = 0; i < exp_starts.size() && i < starts.size(); i++)
            chk("ovr_start_time", starts[i], exp_starts[i]);
        chk("ovr_first_set", obs_ovr, exp_ovr);
        chk("ovr_sticky", b_if.overrun, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mic_adc_reader.md
Name: mic_adc_reader

Overview:
- SPI master that reads the Pmod MIC3 (ADCS7476-style 12-bit serial ADC) on the JA connector.
- Gives the sound-generator designs an audio input path: microphone into 12-bit samples at a fixed rate.
- Runs on the 25 MHz prescaled clock.
- Output samples feed loopback, metering and LFO/mixer experiments.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period (SCLK = clk / (2*CLK_DIV)); legal range ≥1.
- SAMPLE_DIV, 2500: clk cycles between conversion requests (10 kHz at 25 MHz); legal range ≥2.

Ports:
- clk  in  1  system clock (25 MHz).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, the sample timer runs and conversions are requested.
- miso  in  1  ADC serial data out.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  ADC serial clock; idles high.
- sample  out  12  last converted value, unsigned offset-binary.
- sample_signed  out  12  sample with its MSB inverted (two's complement, centred on 0).
- sample_valid  out  1  one-cycle pulse when sample/sample_signed/frame_err update.
- frame_err  out  1  valid with sample_valid; 1 if any of the 4 leading bits was nonzero.
- overrun  out  1  sticky; set when a timer tick arrives while not IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - cs_n=1, sclk=1.
  - sample=0, sample_signed=12'h800, sample_valid=0, frame_err=0, overrun=0.
  - Timer=0, state=IDLE.
  - Reset mid-conversion aborts the frame immediately: no sample_valid, and sample keeps its reset value.
- Sample timer:
  - Counts only while enable=1; forced to 0 while enable=0.
  - At count SAMPLE_DIV-1 it wraps to 0 and emits a one-cycle tick.
  - The first tick comes SAMPLE_DIV cycles after enable rises.
- States: IDLE, CONV, HOLD, QUIET.
- IDLE:
  - On tick, go to CONV. The registered cs_n is low in the next cycle; call that cycle t=0.
- CONV:
  - SCLK falling edges at t = CLK_DIV*(2k+1), rising edges at t = CLK_DIV*(2k+2), for k=0..15 (16 bits).
  - miso is captured by the clk edge that drives sclk high, shifted MSB-first into a 16-bit register.
  - After the 16th rising edge, go to HOLD.
- HOLD:
  - Lasts CLK_DIV cycles, with sclk high and cs_n low.
  - Then cs_n goes high at t = 33*CLK_DIV.
  - In that same cycle: sample = shift[11:0], sample_signed = {~shift[11], shift[10:0]}, frame_err = |shift[15:12], sample_valid=1.
- QUIET:
  - cs_n stays high for 2*CLK_DIV cycles, then return to IDLE.
  - The minimum frame period is 35*CLK_DIV+1 cycles.
- Overrun:
  - A tick in CONV, HOLD or QUIET is dropped and sets overrun=1.
  - overrun clears only on reset.
  - A tick in the same cycle as the QUIET→IDLE transition is also dropped.
- enable falling mid-frame: the current frame completes normally, including sample_valid; no new frames start.
- sample and frame_err hold their values between sample_valid pulses.
- sclk and cs_n are driven directly from flops (glitch-free).

Test Plan:
- CLK_DIV=2, SAMPLE_DIV=100, ADC model drives 16'h0ABC on SCLK falling edges:
  - sample=12'hABC, sample_signed=12'h2BC, frame_err=0.
  - sample_valid is a single pulse 66 cycles after cs_n falls.
  - Exactly 16 sclk rising edges.
- Same setup, ADC drives 16'h8123: sample=12'h123, sample_signed=12'h923, frame_err=1 for that frame only; the next frame with 16'h0000 gives frame_err=0, sample=0.
- Timing with enable held high for 1000 cycles:
  - cs_n falls every 100 cycles (10 frames).
  - No sclk toggles while cs_n=1.
  - cs_n high for ≥4 cycles between frames.
  - overrun stays 0.
- CLK_DIV=2, SAMPLE_DIV=50 (shorter than the 71-cycle frame): overrun rises at the second tick and stays 1; frames start only on ticks that arrive in IDLE.
- Assert reset at t=20 of a frame: cs_n=1 and sclk=1 immediately, no sample_valid; after release with enable=1, the next frame is correct.
- Drop enable at t=10 of a frame: that frame completes with sample_valid; no further cs_n falls; timer reads 0.
